multicycle_ctrl: RTL and testbench

- Control FSM for the multicycle miniRV core.
- Sequences the 32-bit enable-gated state registers (PC, IR, A/B operand, ALU_OUT, MDR) and the register-file write port, one instruction at a time.
- Drives a single shared memory request handshake for both fetch and load/store.
- Sits between the IR opcode field and the datapath register enables.

---
 rtl/ctrl_pkg.sv | 45 ++++
 rtl/opcode_class_dec.sv | 24 ++
 rtl/multicycle_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle miniRV control path: FSM states,
// RV32I major opcodes, datapath select codes and the instruction-class enum.
package ctrl_pkg;

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd7;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
    localparam logic [1:0] PC_SEL_BR   = 2'd1;
    localparam logic [1:0] PC_SEL_JALR = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MDR = 2'd1;
    localparam logic [1:0] WB_SEL_PC  = 2'd2;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_ALU,
        CLS_UPPER,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_ILLEGAL
    } instr_class_t;

    function automatic logic is_mem_class(input instr_class_t cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/opcode_class_dec.sv
// Maps the IR major opcode onto the instruction class the sequencer acts on;
// anything outside the supported RV32I subset is ILLEGAL.
module opcode_class_dec
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_LOAD:               cls = CLS_LOAD;
            OPC_STORE:              cls = CLS_STORE;
            OPC_OP_IMM, OPC_OP:     cls = CLS_ALU;
            OPC_LUI, OPC_AUIPC:     cls = CLS_UPPER;
            OPC_BRANCH:             cls = CLS_BRANCH;
            OPC_JAL:                cls = CLS_JAL;
            OPC_JALR:               cls = CLS_JALR;
            default:                cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle miniRV control FSM: sequences datapath register enables and the
// shared memory handshake, one instruction at a time, with optional memory timeout.
//
//   state   | meaning
//   FETCH   | request instruction at PC; load IR and bump PC on mem_ready
//   DECODE  | latch A/B operands; illegal opcode -> HALT
//   EXECUTE | latch ALU_OUT; branches resolve and retire here
//   MEM     | data request at ALU_OUT; store retires, load fills MDR
//   WB      | register-file write; JAL/JALR redirect PC here
//   HALT    | stopped until rst
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic       ir_en,
    output logic       ab_en,
    output logic       alu_out_en,
    output logic       mdr_en,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       instr_retired,
    output logic       halted,
    output logic [2:0] state
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [2:0]    state_q;
    logic [2:0]    state_nxt;
    logic [CW-1:0] to_cnt;
    logic          mem_wait;
    logic          timeout_hit;
    instr_class_t  cls;

    opcode_class_dec u_dec (
        .opcode (opcode),
        .cls    (cls)
    );

    // Wait cycles are judged on the registered state so the counter does not
    // depend on the reset-gated outputs.
    assign mem_wait    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign timeout_hit = (MEM_TIMEOUT > 0) && mem_wait && (int'(to_cnt) == MEM_TIMEOUT - 1);

    always_comb begin
        state_nxt     = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        pc_en         = 1'b0;
        pc_sel        = PC_SEL_SEQ;
        ir_en         = 1'b0;
        ab_en         = 1'b0;
        alu_out_en    = 1'b0;
        mdr_en        = 1'b0;
        rf_we         = 1'b0;
        wb_sel        = WB_SEL_ALU;
        instr_retired = 1'b0;
        halted        = 1'b0;
        state         = 3'd0;
        if (rst) begin
            state_nxt = S_FETCH;
        end else begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_en     = 1'b1;
                        pc_en     = 1'b1;
                        state_nxt = S_DECODE;
                    end else if (timeout_hit) begin
                        state_nxt = S_HALT;
                    end
                end
                S_DECODE: begin
                    ab_en     = 1'b1;
                    state_nxt = (cls == CLS_ILLEGAL) ? S_HALT : S_EXECUTE;
                end
                S_EXECUTE: begin
                    alu_out_en = 1'b1;
                    if (cls == CLS_BRANCH) begin
                        pc_en         = branch_taken;
                        pc_sel        = PC_SEL_BR;
                        instr_retired = 1'b1;
                        state_nxt     = S_FETCH;
                    end else if (is_mem_class(cls)) begin
                        state_nxt = S_MEM;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (cls == CLS_STORE);
                    if (mem_ready) begin
                        if (cls == CLS_LOAD) begin
                            mdr_en    = 1'b1;
                            state_nxt = S_WB;
                        end else begin
                            instr_retired = 1'b1;
                            state_nxt     = S_FETCH;
                        end
                    end else if (timeout_hit) begin
                        state_nxt = S_HALT;
                    end
                end
                S_WB: begin
                    rf_we         = 1'b1;
                    instr_retired = 1'b1;
                    state_nxt     = S_FETCH;
                    case (cls)
                        CLS_LOAD: wb_sel = WB_SEL_MDR;
                        CLS_JAL: begin
                            wb_sel = WB_SEL_PC;
                            pc_en  = 1'b1;
                            pc_sel = PC_SEL_BR;
                        end
                        CLS_JALR: begin
                            wb_sel = WB_SEL_PC;
                            pc_en  = 1'b1;
                            pc_sel = PC_SEL_JALR;
                        end
                        default: wb_sel = WB_SEL_ALU;
                    endcase
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_nxt = S_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (MEM_TIMEOUT == 0) || !mem_wait || (state_nxt != state_q)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle check of the multicycle control FSM outputs,
// with a second instance configured for a 4-cycle memory timeout.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mr, mr2;

    logic       a_req, a_we, a_as, a_pe, a_ir, a_ab, a_ao, a_md, a_rw, a_rt, a_hl;
    logic [1:0] a_ps, a_ws;
    logic [2:0] a_st;
    logic       b_req, b_we, b_as, b_pe, b_ir, b_ab, b_ao, b_md, b_rw, b_rt, b_hl;
    logic [1:0] b_ps, b_ws;
    logic [2:0] b_st;

    int nvec = 0;
    int nmis = 0;
    logic sel_to = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mr), .mem_req(a_req), .mem_we(a_we), .mem_addr_sel(a_as),
        .pc_en(a_pe), .pc_sel(a_ps), .ir_en(a_ir), .ab_en(a_ab),
        .alu_out_en(a_ao), .mdr_en(a_md), .rf_we(a_rw), .wb_sel(a_ws),
        .instr_retired(a_rt), .halted(a_hl), .state(a_st)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mr2), .mem_req(b_req), .mem_we(b_we), .mem_addr_sel(b_as),
        .pc_en(b_pe), .pc_sel(b_ps), .ir_en(b_ir), .ab_en(b_ab),
        .alu_out_en(b_ao), .mdr_en(b_md), .rf_we(b_rw), .wb_sel(b_ws),
        .instr_retired(b_rt), .halted(b_hl), .state(b_st)
    );

    logic [17:0] o_a, o_b;
    assign o_a = {a_st, a_hl, a_rt, a_ws, a_rw, a_md, a_ao, a_ab, a_ir, a_ps, a_pe, a_as, a_we, a_req};
    assign o_b = {b_st, b_hl, b_rt, b_ws, b_rw, b_md, b_ao, b_ab, b_ir, b_ps, b_pe, b_as, b_we, b_req};

    function automatic logic [17:0] mk(input logic [2:0] st, input logic hl, rt,
                                       input logic [1:0] ws, input logic rw, md, ao, ab, ir,
                                       input logic [1:0] ps, input logic pe, as_, we, rq);
        return {st, hl, rt, ws, rw, md, ao, ab, ir, ps, pe, as_, we, rq};
    endfunction

    // Checks the current cycle's outputs at the falling edge, then advances
    // to just after the next rising edge where the next cycle's inputs go in.
    task automatic ex(input string tag, input logic [17:0] e);
        logic [17:0] obs;
        @(negedge clk);
        obs = sel_to ? o_b : o_a;
        nvec++;
        assert (obs === e)
        else begin
            nmis++;
            $error("FAIL %s: outputs %b, expected %b", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    logic [17:0] V_ZERO, V_F, V_FW, V_D, V_E, V_EBT, V_EBN, V_MLW, V_MLR;
    logic [17:0] V_MSR, V_MSW, V_WA, V_WL, V_WJAL, V_WJALR, V_HALT;

    initial begin
        //                st    hl rt ws rw md ao ab ir ps pe as we rq
        V_ZERO  = '0;
        V_F     = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
        V_FW    = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        V_D     = mk(3'd1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        V_E     = mk(3'd2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        V_EBT   = mk(3'd2, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        V_EBN   = mk(3'd2, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        V_MLW   = mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        V_MLR   = mk(3'd3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        V_MSR   = mk(3'd3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        V_MSW   = mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        V_WA    = mk(3'd4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        V_WL    = mk(3'd4, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        V_WJAL  = mk(3'd4, 0, 1, 2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        V_WJALR = mk(3'd4, 0, 1, 2, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        V_HALT  = mk(3'd7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1; mr = 1'b1; mr2 = 1'b1; opcode = 7'b0110011; branch_taken = 1'b0;
        @(posedge clk); #1;
        ex("rst_c0", V_ZERO);
        ex("rst_c1", V_ZERO);
        rst = 1'b0;

        ex("op_fetch", V_F);
        ex("op_decode", V_D);
        ex("op_exec", V_E);
        ex("op_wb", V_WA);

        opcode = 7'b0000011;
        ex("ld_fetch", V_F);
        ex("ld_decode", V_D);
        ex("ld_exec", V_E);
        mr = 1'b0;
        ex("ld_mem_w1", V_MLW);
        ex("ld_mem_w2", V_MLW);
        mr = 1'b1;
        ex("ld_mem_rdy", V_MLR);
        ex("ld_wb", V_WL);

        opcode = 7'b1100011; branch_taken = 1'b1;
        ex("bt_fetch", V_F);
        ex("bt_decode", V_D);
        ex("bt_exec", V_EBT);
        branch_taken = 1'b0;
        ex("bn_fetch", V_F);
        ex("bn_decode", V_D);
        ex("bn_exec", V_EBN);

        opcode = 7'b0100011;
        ex("st_fetch", V_F);
        ex("st_decode", V_D);
        ex("st_exec", V_E);
        ex("st_mem", V_MSR);

        opcode = 7'b0110111;
        ex("lui_fetch", V_F);
        ex("lui_decode", V_D);
        ex("lui_exec", V_E);
        ex("lui_wb", V_WA);

        opcode = 7'b1101111;
        ex("jal_fetch", V_F);
        ex("jal_decode", V_D);
        ex("jal_exec", V_E);
        ex("jal_wb", V_WJAL);

        opcode = 7'b1100111;
        ex("jalr_fetch", V_F);
        ex("jalr_decode", V_D);
        ex("jalr_exec", V_E);
        ex("jalr_wb", V_WJALR);

        opcode = 7'b1110011;
        ex("ill_fetch", V_F);
        ex("ill_decode", V_D);
        ex("ill_halt0", V_HALT);
        ex("ill_halt1", V_HALT);
        rst = 1'b1;
        ex("ill_rst", V_ZERO);
        rst = 1'b0;
        opcode = 7'b0110011;
        mr = 1'b0; mr2 = 1'b0;

        sel_to = 1'b1;
        ex("to_wait1", V_FW);
        ex("to_wait2", V_FW);
        ex("to_wait3", V_FW);
        ex("to_wait4", V_FW);
        ex("to_halt", V_HALT);
        sel_to = 1'b0;
        ex("noto_wait6", V_FW);

        rst = 1'b1;
        ex("st2_rst", V_ZERO);
        rst = 1'b0; mr = 1'b1; opcode = 7'b0100011;
        ex("st2_fetch", V_F);
        ex("st2_decode", V_D);
        ex("st2_exec", V_E);
        mr = 1'b0;
        ex("st2_mem_wait", V_MSW);
        rst = 1'b1;
        ex("st2_abort", V_ZERO);
        rst = 1'b0;
        ex("st2_refetch", V_FW);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
